// File: rtl/layer2_conv3x3.sv
// layer2_conv3x3: 3x3 Laplacian convolution over the 32x32 layer-1 map.
// Reads layer 1 through the shared CNN memory port one tap per cycle,
// accumulates with bias, applies ReLU + saturation and writes the 32x32
// layer-2 map, then pulses done.
//
// Optional build macro SKIP_ZERO_TAPS_EN: skip the four zero-weight corner
// taps (5 reads per pixel, 7 cycles per pixel instead of 11).
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start           one-cycle request, honoured only in IDLE
//   busy, done      status; done is a one-cycle pulse after the last write
//   mem_sel, mem_rd, mem_raddr, mem_rdata   shared memory read port
//                   (mem_rdata is valid in the cycle after the address is
//                   registered)
//   l2_wr, l2_addr, l2_data                 layer-2 memory write port
module layer2_conv3x3 #(
    parameter int DIM    = 32,
    parameter int DATA_W = 13,
    parameter int BIAS   = -8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_sel,
    output logic              mem_rd,
    output logic [11:0]       mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              l2_wr,
    output logic [9:0]        l2_addr,
    output logic [DATA_W-1:0] l2_data
);

    localparam int LW = $clog2(DIM);
    localparam logic [9:0] LAST_PX = 10'(DIM * DIM - 1);
    localparam logic signed [15:0] BIAS16 = 16'(BIAS);
`ifdef SKIP_ZERO_TAPS_EN
    localparam logic [3:0] LAST_CNT = 4'd5;
`else
    localparam logic [3:0] LAST_CNT = 4'd9;
`endif

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t               state;
    logic [9:0]           center;
    logic [3:0]           counter;
    logic signed [15:0]   acc;
    logic [3:0]           t_acc;
    logic signed [15:0]   acc_term;
    logic [9:0]           issue_addr;

    // Kernel tap (row-major 0..8) served at schedule slot idx.
    function automatic logic [3:0] tap_id(input logic [3:0] idx);
`ifdef SKIP_ZERO_TAPS_EN
        case (idx)
            4'd0:    return 4'd1;
            4'd1:    return 4'd3;
            4'd2:    return 4'd4;
            4'd3:    return 4'd5;
            4'd4:    return 4'd7;
            default: return 4'd4;
        endcase
`else
        return idx;
`endif
    endfunction

    function automatic int tap_dr(input logic [3:0] t);
        return int'(t) / 3 - 1;
    endfunction

    function automatic int tap_dc(input logic [3:0] t);
        return int'(t) % 3 - 1;
    endfunction

    // Tap address with row/col clamped into the map; padding taps still read.
    function automatic logic [9:0] tap_addr(input logic [9:0] ctr, input logic [3:0] t);
        int r;
        int c;
        r = int'(ctr[2*LW-1:LW]) + tap_dr(t);
        c = int'(ctr[LW-1:0]) + tap_dc(t);
        if (r < 0) r = 0;
        else if (r > DIM - 1) r = DIM - 1;
        if (c < 0) c = 0;
        else if (c > DIM - 1) c = DIM - 1;
        return 10'(r * DIM + c);
    endfunction

    // True when the tap lies inside the map (outside taps contribute zero).
    function automatic logic tap_valid(input logic [9:0] ctr, input logic [3:0] t);
        int r;
        int c;
        r = int'(ctr[2*LW-1:LW]) + tap_dr(t);
        c = int'(ctr[LW-1:0]) + tap_dc(t);
        return (r >= 0) && (r < DIM) && (c >= 0) && (c < DIM);
    endfunction

    // Laplacian weight applied to one sample: 4 at the centre, -1 on the cross.
    function automatic logic signed [15:0] weighted(input logic [3:0] t, input logic [DATA_W-1:0] d);
        case (t)
            4'd4:                      return $signed({1'b0, d, 2'b00});
            4'd1, 4'd3, 4'd5, 4'd7:    return -$signed({3'b000, d});
            default:                   return 16'sd0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] relu_sat(input logic signed [15:0] a);
        if (a < 16'sd0)
            return {DATA_W{1'b0}};
        else if (a > 16'sd4095)
            return 13'h0FFF;
        else
            return a[DATA_W-1:0];
    endfunction

    // Tap geometry for the slot being issued and the slot whose data is arriving.
    always_comb begin
        issue_addr = tap_addr(center, tap_id(counter));
        t_acc      = tap_id(counter - 4'd1);
        if (tap_valid(center, t_acc))
            acc_term = weighted(t_acc, mem_rdata);
        else
            acc_term = 16'sd0;
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            center    <= 10'd0;
            counter   <= 4'd0;
            acc       <= 16'sd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_sel   <= 1'b0;
            mem_rd    <= 1'b0;
            mem_raddr <= 12'd0;
            l2_wr     <= 1'b0;
            l2_addr   <= 10'd0;
            l2_data   <= {DATA_W{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    l2_wr <= 1'b0;
                    if (start) begin
                        state   <= READ;
                        center  <= 10'd0;
                        counter <= 4'd0;
                        acc     <= BIAS16;
                        busy    <= 1'b1;
                    end
                end
                READ: begin
                    l2_wr <= 1'b0;
                    if (counter != LAST_CNT) begin
                        mem_rd    <= 1'b1;
                        mem_sel   <= 1'b1;
                        mem_raddr <= {2'b00, issue_addr};
                    end else begin
                        mem_rd <= 1'b0;
                    end
                    // Slot 0 has no returning data yet.
                    if (counter != 4'd0)
                        acc <= acc + acc_term;
                    if (counter == LAST_CNT)
                        state <= WRITE;
                    else
                        counter <= counter + 4'd1;
                end
                WRITE: begin
                    l2_wr   <= 1'b1;
                    l2_addr <= center;
                    l2_data <= relu_sat(acc);
                    acc     <= BIAS16;
                    counter <= 4'd0;
                    // The centre wraps back to 0 only when leaving DONE.
                    if (center == LAST_PX) begin
                        state <= DONE;
                    end else begin
                        center <= center + 10'd1;
                        state  <= READ;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    l2_wr   <= 1'b0;
                    mem_sel <= 1'b0;
                    center  <= 10'd0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer2_conv3x3.sv
// Self-checking bench for layer2_conv3x3: memory model, write/read monitor and
// an arithmetic reference of the padded 3x3 Laplacian with bias and ReLU.
module tb_layer2_conv3x3;

`ifdef SKIP_ZERO_TAPS_EN
    localparam int PIX_CYC = 7;
    localparam int TAPS    = 5;
`else
    localparam int PIX_CYC = 11;
    localparam int TAPS    = 9;
`endif
    localparam int N       = 1024;
    localparam int EXP_LAT = PIX_CYC * N + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, mem_sel, mem_rd, l2_wr;
    logic [11:0] mem_raddr;
    logic [12:0] mem_rdata;
    logic [9:0]  l2_addr;
    logic [12:0] l2_data;

    logic [12:0] l1 [N];
    logic [12:0] got [N];
    int          wr_count, rd_count, done_count, viol;
    int          checks = 0;
    int          errors = 0;
    int          first_bad;

    always #5 clk = ~clk;

    layer2_conv3x3 dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_sel(mem_sel), .mem_rd(mem_rd), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .l2_wr(l2_wr), .l2_addr(l2_addr), .l2_data(l2_data)
    );

    assign mem_rdata = l1[mem_raddr[9:0]];

    // Observe the registered outputs mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (l2_wr) begin
                got[l2_addr] = l2_data;
                wr_count++;
            end
            if (mem_rd) rd_count++;
            if (done) done_count++;
            if (mem_rd && l2_wr) viol++;
            if (mem_rd && (!mem_sel || mem_raddr[11:10] != 2'b00)) viol++;
        end
    end

    function automatic int ref_px(int r, int c);
        int a, w;
        a = -8;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                if (dr == 0 && dc == 0) w = 4;
                else if (dr == 0 || dc == 0) w = -1;
                else w = 0;
                if (r + dr >= 0 && r + dr < 32 && c + dc >= 0 && c + dc < 32)
                    a += w * int'(l1[(r + dr) * 32 + c + dc]);
            end
        if (a < 0) return 0;
        if (a > 4095) return 4095;
        return a;
    endfunction

    function automatic int map_errors();
        int n;
        n = 0;
        first_bad = -1;
        for (int i = 0; i < N; i++)
            if (int'(got[i]) != ref_px(i / 32, i % 32)) begin
                if (first_bad < 0) first_bad = i;
                n++;
            end
        return n;
    endfunction

    task automatic clear_mon();
        wr_count = 0; rd_count = 0; done_count = 0; viol = 0;
        for (int i = 0; i < N; i++) got[i] = 13'h1FFF;
    endtask

    // Start one run and its protocol checks; extra_at injects a second start.
    task automatic run_map(input string name, input int extra_at);
        int lat, busy_bad;
        clear_mon();
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        lat = 0; busy_bad = 0;
        while (lat < 20000) begin
            if (done) break;
            if (!busy) busy_bad++;
            start = (lat == extra_at) ? 1'b1 : 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL %s latency got %0d expected %0d", name, lat, EXP_LAT); end
        checks++; if (busy_bad !== 0) begin errors++; $display("FAIL %s busy low %0d cycles expected 0", name, busy_bad); end
        checks++; if (wr_count !== N) begin errors++; $display("FAIL %s writes got %0d expected %0d", name, wr_count, N); end
        checks++; if (done_count !== 1) begin errors++; $display("FAIL %s done pulses got %0d expected 1", name, done_count); end
        checks++; if (rd_count !== TAPS * N) begin errors++; $display("FAIL %s reads got %0d expected %0d", name, rd_count, TAPS * N); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL %s port rule violations got %0d expected 0", name, viol); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy after done got %b expected 0", name, busy); end
    endtask

    task automatic check_map(input string name);
        int n;
        n = map_errors();
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL %s map has %0d wrong pixels, first idx %0d got %0d expected %0d",
                     name, n, first_bad, got[first_bad], ref_px(first_bad / 32, first_bad % 32));
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, mem_sel, mem_rd, mem_raddr, l2_wr, l2_addr, l2_data} !== 50'd0) begin
            errors++; $display("FAIL reset outputs got %h expected 0", {busy, done, mem_sel, mem_rd, mem_raddr, l2_wr, l2_addr, l2_data});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle busy got %b expected 0", busy); end
    endtask

    task automatic test_zero();
        for (int i = 0; i < N; i++) l1[i] = 13'd0;
        run_map("zero", -1);
        check_map("zero");
    endtask

    task automatic test_impulse();
        for (int i = 0; i < N; i++) l1[i] = 13'd0;
        l1[10 * 32 + 10] = 13'd16;
        run_map("impulse", -1);
        check_map("impulse");
        checks++; if (got[330] !== 13'd56) begin errors++; $display("FAIL impulse centre got %0d expected 56", got[330]); end
        checks++; if ({got[298], got[362], got[329], got[331]} !== 52'd0) begin errors++; $display("FAIL impulse neighbours not zero"); end
    endtask

    task automatic test_constant();
        for (int i = 0; i < N; i++) l1[i] = 13'd32;
        run_map("const", -1);
        check_map("const");
        checks++; if (got[0] !== 13'd56) begin errors++; $display("FAIL const corner got %0d expected 56", got[0]); end
        checks++; if (got[5] !== 13'd24) begin errors++; $display("FAIL const edge05 got %0d expected 24", got[5]); end
        checks++; if (got[31 * 32 + 17] !== 13'd24) begin errors++; $display("FAIL const edge3117 got %0d expected 24", got[31 * 32 + 17]); end
        checks++; if (got[15 * 32 + 15] !== 13'd0) begin errors++; $display("FAIL const interior got %0d expected 0", got[495]); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < N; i++) l1[i] = 13'd0;
        l1[165] = 13'd4095;
        run_map("sat", -1);
        check_map("sat");
        checks++; if (got[165] !== 13'h0FFF) begin errors++; $display("FAIL sat centre got %0d expected 4095", got[165]); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < N; i++) l1[i] = 13'($urandom_range(0, 4095));
        clear_mon();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (500) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, mem_sel, mem_rd, mem_raddr, l2_wr, l2_addr, l2_data} !== 50'd0) begin
            errors++; $display("FAIL midreset outputs got %h expected 0", {busy, done, mem_sel, mem_rd, mem_raddr, l2_wr, l2_addr, l2_data});
        end
        @(negedge clk) reset = 1'b0;
        wr_count = 0;
        repeat (20) @(negedge clk);
        checks++; if (wr_count !== 0 || busy !== 1'b0) begin errors++; $display("FAIL midreset idle writes %0d busy %b expected 0 0", wr_count, busy); end
        run_map("recover", -1);
        check_map("recover");
    endtask

    task automatic test_double_start();
        for (int i = 0; i < N; i++) l1[i] = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(0, 4095)) : 13'd0;
        run_map("dblstart", 100);
        check_map("dblstart");
    endtask

    initial begin
        test_reset();
        test_zero();
        test_impulse();
        test_constant();
        test_saturate();
        test_reset_mid();
        test_double_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
